// File: rtl/pc_target_pkg.sv
// Shared types for the programmable branch-target table: entry layout,
// sweep/idle FSM states and default widths.
package pc_target_pkg;

    localparam int unsigned PC_W_DEF   = 12;
    localparam int unsigned ADDR_W_DEF = 6;

    typedef struct packed {
        logic                valid;
        logic                abs;
        logic [PC_W_DEF-1:0] target;
    } entry_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    function automatic entry_t make_entry(input logic abs, input logic [PC_W_DEF-1:0] target);
        entry_t e;
        e.valid  = 1'b1;
        e.abs    = abs;
        e.target = target;
        return e;
    endfunction

endpackage

// File: rtl/pc_target_ram.sv
// Entry storage: one synchronous write port, one combinational read port.
// Contents are not reset; validity is established by the owner's sweep.
module pc_target_ram
    import pc_target_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  entry_t            wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output entry_t            rdata_c
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/pc_target_table.sv
// Programmable branch-target table: invalidating sweep FSM, run-time entry
// writes with write-to-lookup bypass, and a registered next-PC computation.
module pc_target_table
    import pc_target_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PC_W-1:0]   wr_target,
    input  logic              wr_abs,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              taken,
    output logic              nxt_valid,
    output logic [PC_W-1:0]   next_pc,
    output logic              miss
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q;
    logic              sweep_we;

    logic              nxt_valid_q;
    logic [PC_W-1:0]   next_pc_q;
    logic              miss_q;

    logic              user_we;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    entry_t            ram_wdata;
    entry_t            user_entry;
    entry_t            rd_entry;
    entry_t            lu_entry;
    logic              lu_acc;
    logic [PC_W-1:0]   res_pc;
    logic              res_miss;

    // State register; busy_q mirrors "state is not IDLE" as a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Sweep writes one invalid entry per cycle; clear always restarts at 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        case (state_q)
            INIT, CLEAR: begin
                sweep_we = 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                sweep_we = 1'b0;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
        if (clear) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end

    // A clear in the same cycle drops the user write.
    assign user_we    = wr_en && !busy_q && !clear;
    assign user_entry = make_entry(wr_abs, wr_target);

    assign ram_we    = sweep_we || user_we;
    assign ram_waddr = busy_q ? cnt_q : wr_addr;
    assign ram_wdata = busy_q ? entry_t'('0) : user_entry;

    pc_target_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (lu_addr),
        .rdata_c (rd_entry)
    );

    assign lu_acc   = lu_valid && !busy_q;
    assign lu_entry = (user_we && (wr_addr == lu_addr)) ? user_entry : rd_entry;

    // Next-PC rules; all sums wrap modulo 2**PC_W.
    always_comb begin
        res_pc   = pc_in + PC_W'(1);
        res_miss = 1'b0;
        if (taken) begin
            if (!lu_entry.valid) begin
                res_pc   = pc_in;
                res_miss = 1'b1;
            end else if (lu_entry.abs) begin
                res_pc = lu_entry.target;
            end else begin
                res_pc = pc_in + lu_entry.target;
            end
        end
    end

    // Result registers; next_pc/miss hold when no lookup is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nxt_valid_q <= 1'b0;
            next_pc_q   <= '0;
            miss_q      <= 1'b0;
        end else begin
            nxt_valid_q <= lu_acc;
            if (lu_acc) begin
                next_pc_q <= res_pc;
                miss_q    <= res_miss;
            end
        end
    end

    assign busy      = busy_q;
    assign nxt_valid = nxt_valid_q;
    assign next_pc   = next_pc_q;
    assign miss      = miss_q;

endmodule

// File: tb/tb_pc_target_table.sv
// Bench for pc_target_table: directed scenarios followed by random traffic,
// all compared against a table-level reference model every cycle.
module tb_pc_target_table;

    localparam int unsigned PC_W   = 12;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;
    localparam int          PC_MOD = 4096;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              clear;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PC_W-1:0]   wr_target;
    logic              wr_abs;
    logic              lu_valid;
    logic [ADDR_W-1:0] lu_addr;
    logic [PC_W-1:0]   pc_in;
    logic              taken;
    logic              nxt_valid;
    logic [PC_W-1:0]   next_pc;
    logic              miss;

    pc_target_table dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_target (wr_target),
        .wr_abs    (wr_abs),
        .lu_valid  (lu_valid),
        .lu_addr   (lu_addr),
        .pc_in     (pc_in),
        .taken     (taken),
        .nxt_valid (nxt_valid),
        .next_pc   (next_pc),
        .miss      (miss)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: table contents, remaining busy cycles, expected outputs.
    bit m_valid [DEPTH];
    bit m_abs   [DEPTH];
    int m_tgt   [DEPTH];
    int busy_left;
    bit e_nv;
    int e_pc;
    bit e_miss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        clear     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_target = '0;
        wr_abs    = 1'b0;
        lu_valid  = 1'b0;
        lu_addr   = '0;
        pc_in     = '0;
        taken     = 1'b0;
    endtask

    task automatic model_invalidate();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_valid[i] = 1'b0;
            m_abs[i]   = 1'b0;
            m_tgt[i]   = 0;
        end
    endtask

    // One clock with the currently driven inputs; model predicts, DUT is checked.
    task automatic cycle();
        bit bz;
        int a;
        bz = (busy_left > 0);
        check("busy", 32'(busy), 32'(bz));
        if (!bz && wr_en && !clear) begin
            a = int'(wr_addr);
            m_valid[a] = 1'b1;
            m_abs[a]   = wr_abs;
            m_tgt[a]   = int'(wr_target);
        end
        if (!bz && lu_valid) begin
            a      = int'(lu_addr);
            e_nv   = 1'b1;
            e_miss = 1'b0;
            if (!taken) begin
                e_pc = (int'(pc_in) + 1) % PC_MOD;
            end else if (!m_valid[a]) begin
                e_pc   = int'(pc_in);
                e_miss = 1'b1;
            end else if (m_abs[a]) begin
                e_pc = m_tgt[a];
            end else begin
                e_pc = (int'(pc_in) + m_tgt[a]) % PC_MOD;
            end
        end else begin
            e_nv = 1'b0;
        end
        if (clear) begin
            busy_left = int'(DEPTH);
            model_invalidate();
        end else if (busy_left > 0) begin
            busy_left--;
        end
        @(posedge clk);
        #1;
        check("nxt_valid", 32'(nxt_valid), 32'(e_nv));
        check("next_pc", 32'(next_pc), 32'(e_pc));
        check("miss", 32'(miss), 32'(e_miss));
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_nxt_valid", 32'(nxt_valid), 32'd0);
        check("rst_next_pc", 32'(next_pc), 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        busy_left = int'(DEPTH);
        e_nv      = 1'b0;
        e_pc      = 0;
        e_miss    = 1'b0;
        model_invalidate();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic do_write(input int addr, input int tgt, input bit abs);
        set_idle();
        wr_en     = 1'b1;
        wr_addr   = ADDR_W'(addr);
        wr_target = PC_W'(tgt);
        wr_abs    = abs;
    endtask

    task automatic do_lookup(input int addr, input int pc, input bit tk);
        lu_valid = 1'b1;
        lu_addr  = ADDR_W'(addr);
        pc_in    = PC_W'(pc);
        taken    = tk;
    endtask

    initial begin
        reset_n = 1'b1;
        set_idle();
        #2;
        do_reset();

        // 1: sweep after reset, then a taken lookup to an invalid entry
        idle_cycles(int'(DEPTH));
        set_idle();
        do_lookup(5, 'h010, 1'b1);
        cycle();
        check("t1_nv", 32'(nxt_valid), 32'd1);
        check("t1_miss", 32'(miss), 32'd1);
        check("t1_pc", 32'(next_pc), 32'h010);

        // 2: relative entries, back-to-back lookups
        do_write(0, 'hFFB, 1'b0); cycle();
        do_write(1, 'h014, 1'b0); cycle();
        set_idle(); do_lookup(0, 'h004, 1'b1); cycle();
        check("t2_neg", 32'(next_pc), 32'hFFF);
        set_idle(); do_lookup(1, 'h004, 1'b1); cycle();
        check("t2_pos", 32'(next_pc), 32'h018);
        check("t2_nv", 32'(nxt_valid), 32'd1);

        // 3: absolute entry, taken and not taken
        do_write(2, 'h123, 1'b1); cycle();
        set_idle(); do_lookup(2, 'h7FF, 1'b1); cycle();
        check("t3_abs", 32'(next_pc), 32'h123);
        set_idle(); do_lookup(2, 'h7FF, 1'b0); cycle();
        check("t3_nt", 32'(next_pc), 32'h800);
        check("t3_miss", 32'(miss), 32'd0);

        // 4: wrap-around
        set_idle(); do_lookup(2, 'hFFF, 1'b0); cycle();
        check("t4_inc_wrap", 32'(next_pc), 32'h000);
        set_idle(); do_lookup(1, 'hFF0, 1'b1); cycle();
        check("t4_rel_wrap", 32'(next_pc), 32'h004);
        idle_cycles(1);
        check("t4_hold_pc", 32'(next_pc), 32'h004);
        check("t4_hold_nv", 32'(nxt_valid), 32'd0);

        // 5: write/lookup bypass, then clear beats a concurrent write
        do_write(3, 'h002, 1'b0); do_lookup(3, 'h100, 1'b1); cycle();
        check("t5_bypass", 32'(next_pc), 32'h102);
        do_write(4, 'h055, 1'b1); clear = 1'b1; cycle();
        check("t5_busy", 32'(busy), 32'd1);
        idle_cycles(int'(DEPTH));
        set_idle(); do_lookup(4, 'h200, 1'b1); cycle();
        check("t5_dropped", 32'(miss), 32'd1);

        // 6: lookup during sweep dropped; table invalid after sweep; reset mid-sweep
        do_write(0, 'h0AA, 1'b1); cycle();
        set_idle(); clear = 1'b1; cycle();
        idle_cycles(9);
        set_idle(); do_lookup(0, 'h300, 1'b1); cycle();
        check("t6_sweep_drop", 32'(nxt_valid), 32'd0);
        idle_cycles(int'(DEPTH) - 10);
        set_idle(); do_lookup(0, 'h300, 1'b1); cycle();
        check("t6_miss", 32'(miss), 32'd1);
        check("t6_pc", 32'(next_pc), 32'h300);
        set_idle(); clear = 1'b1; cycle();
        idle_cycles(20);
        do_reset();
        idle_cycles(int'(DEPTH));
        check("t6_idle_after", 32'(busy), 32'd0);

        // Random traffic over a small address window to get frequent hits
        for (int n = 0; n < 600; n++) begin
            set_idle();
            clear     = ($urandom_range(0, 149) == 0);
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = ADDR_W'($urandom_range(0, 7));
            wr_target = PC_W'($urandom);
            wr_abs    = 1'($urandom_range(0, 1));
            lu_valid  = 1'($urandom_range(0, 1));
            lu_addr   = ADDR_W'($urandom_range(0, 7));
            pc_in     = PC_W'($urandom);
            taken     = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_target_table.md
Name: pc_target_table

Overview:
Programmable successor to the fixed branch-offset lookup table. It holds DEPTH branch-target entries, each either PC-relative (signed offset) or absolute. Each entry is writable at run time. On a lookup it computes the registered next PC directly. It sits between the decoder (lookup index, taken flag) and the PC register; the loader or test harness fills entries through the write port.

Parameters:
PC_W, 12, PC and target/offset width; all PC arithmetic is mod 2**PC_W
ADDR_W, 6, table index width
DEPTH, 2**ADDR_W, number of entries (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  single-cycle pulse; invalidates the whole table via a sweep
busy  out  1  high while a sweep is in progress; writes and lookups are ignored
wr_en  in  1  write strobe; accepted only when busy=0
wr_addr  in  ADDR_W  entry index
wr_target  in  PC_W  offset (two's complement) or absolute target
wr_abs  in  1  1 = absolute entry, 0 = relative entry
lu_valid  in  1  lookup request
lu_addr  in  ADDR_W  entry index
pc_in  in  PC_W  current PC
taken  in  1  branch taken
nxt_valid  out  1  next_pc/miss valid (one cycle after an accepted lookup)
next_pc  out  PC_W  computed next PC
miss  out  1  taken lookup hit an invalid entry

Behaviour:
- Entry = {valid, abs, target[PC_W]}. Storage has no reset; validity is established by the sweep.
- Reset (reset_n low, async): FSM -> INIT, sweep counter = 0, busy=1, nxt_valid=0, next_pc=0, miss=0.
- FSM states:
  - INIT/CLEAR: write invalid zero entry at counter, then increment. At counter==DEPTH-1, write and go to IDLE. busy is high for exactly DEPTH cycles after reset release or after a clear pulse.
  - IDLE: busy=0. A clear pulse -> CLEAR with counter=0.
- clear while busy: restart the sweep at 0. clear and wr_en in the same cycle: clear wins, the write is dropped.
- Reset asserted mid-sweep: restart in INIT.
- Write (IDLE, wr_en): entry[wr_addr] <= {1, wr_abs, wr_target}, visible to a lookup in the next cycle.
- Lookup accepted when lu_valid && !busy. Result is registered; latency 1. Lookups while busy are dropped: nxt_valid=0 the following cycle.
- Same-cycle write and lookup to the same index: the lookup uses the new write data (bypass).
- Result rules (E = entry[lu_addr]):
  - taken=0: next_pc = pc_in+1, miss=0.
  - taken=1, E.valid=0: next_pc = pc_in (hold), miss=1.
  - taken=1, E.abs=1: next_pc = E.target, miss=0.
  - taken=1, E.abs=0: next_pc = (pc_in + E.target) mod 2**PC_W, i.e. signed offset, carry discarded; miss=0.
- With no accepted lookup, nxt_valid=0. next_pc and miss hold their last values.
- Pipelined back-to-back lookups are supported, one per cycle.

Decomposition:
- Package pc_target_pkg: entry struct typedef (valid, abs, target), FSM state enum {INIT, IDLE, CLEAR}, PC_W/ADDR_W defaults.
- Sub-module pc_target_ram: DEPTH x entry storage, one write port and one combinational read port, no reset.
- Top module holds the FSM, sweep counter, write mux (sweep vs. user), bypass, next-PC arithmetic and output registers.

Test Plan:
1. Release reset -> busy=1 for 64 cycles, then 0. Lookup addr 5, pc_in=0x010, taken=1 -> next cycle nxt_valid=1, miss=1, next_pc=0x010.
2. Write addr0=0xFFB rel and addr1=0x014 rel. Lookup addr0, pc 0x004, taken -> 0xFFF. Lookup addr1, pc 0x004, taken -> 0x018 (back-to-back, consecutive cycles).
3. Write addr2=0x123 abs. Lookup pc 0x7FF taken -> 0x123. Same with taken=0 -> 0x800, miss=0.
4. Wrap-around: pc 0xFFF, taken=0 -> 0x000. Addr1 (+20), pc 0xFF0, taken -> 0x004.
5. Same cycle: write addr3=0x002 rel and lookup addr3, pc 0x100, taken -> 0x102. Then clear and wr_en together -> write dropped.
6. Pulse clear. Lookup at sweep cycle 10 -> nxt_valid=0. After 64 cycles, lookup addr0 taken -> miss=1. Assert reset_n=0 mid-sweep -> outputs 0 and busy stays high for 64 cycles after release.
